// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII frame generator and its CRC helper.
// Constants only; no timing or flow-control behaviour lives here.
package gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_FCS,
        ST_GAP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32, LSB of the byte first.
// Zero latency, no flow control: the caller decides when to register the result.
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  dat_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    logic [31:0] crc_tmp;

    always_comb begin
        crc_tmp = crc_i;
        for (int b = 0; b < 8; b++) begin
            if (crc_tmp[0] ^ dat_i[b]) begin
                crc_tmp = (crc_tmp >> 1) ^ POLY_REFL;
            end else begin
                crc_tmp = crc_tmp >> 1;
            end
        end
        crc_o = crc_tmp;
    end

endmodule

// File: rtl/gmii_frame_gen.sv
// Replays a buffered frame onto GMII rx with preamble/SFD, optional FCS, gap, repeats and error injection.
// Outputs are registered and trail the FSM state by one clock; no backpressure, the line is always driven.
module gmii_frame_gen
    import gmii_pkg::*;
#(
    parameter int MAXNBYTES = 2048,
    parameter int AW        = $clog2(MAXNBYTES),
    parameter int IFG       = 12,
    parameter int NPRE      = 7,
    parameter int CNTW      = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [7:0]      wr_data,
    input  logic [AW:0]     frame_len,
    input  logic            start,
    input  logic [15:0]     repeat_cnt,
    input  logic            fcs_en,
    input  logic            err_en,
    input  logic [AW:0]     err_idx,
    output logic [7:0]      rxd,
    output logic            rx_dv,
    output logic            rx_er,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] frames_sent
);

    localparam int          CW      = (AW + 1 > 16) ? AW + 1 : 16;
    localparam logic [AW:0] MAX_LEN = (AW + 1)'(MAXNBYTES);

    logic [1:0]      rst_sync_q;
    logic            rst_n;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     len_q, len_d;
    logic [15:0]     rep_q, rep_d;
    logic            fcs_en_q, fcs_en_d;
    logic            err_en_q, err_en_d;
    logic [AW:0]     err_idx_q, err_idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      rxd_q, rxd_d;
    logic            rx_dv_q, rx_dv_d;
    logic            rx_er_q, rx_er_d;
    logic [CNTW-1:0] frames_q, frames_d;
    logic [31:0]     crc_q, crc_d, crc_nxt, fcs_val;
    logic [AW-1:0]   rd_addr;
    logic [7:0]      rd_dat_q;
    logic [7:0]      mem [MAXNBYTES];

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem[wr_addr] <= wr_data;
        end
        rd_dat_q <= mem[rd_addr];
    end

    crc32_d8 u_crc (
        .crc_i (crc_q),
        .dat_i (rd_dat_q),
        .crc_o (crc_nxt)
    );

    assign fcs_val = ~crc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        len_d     = len_q;
        rep_d     = rep_q;
        fcs_en_d  = fcs_en_q;
        err_en_d  = err_en_q;
        err_idx_d = err_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rxd_d     = '0;
        rx_dv_d   = 1'b0;
        rx_er_d   = 1'b0;
        frames_d  = frames_q;
        crc_d     = crc_q;
        rd_addr   = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // The frame's last idle byte leaves the output register one clock after GAP ends.
                if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (start && frame_len != '0 && repeat_cnt != '0) begin
                    state_d   = ST_PRE;
                    busy_d    = 1'b1;
                    len_d     = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
                    rep_d     = repeat_cnt;
                    fcs_en_d  = fcs_en;
                    err_en_d  = err_en;
                    err_idx_d = err_idx;
                end
            end
            ST_PRE: begin
                rxd_d   = PREAMBLE_BYTE;
                rx_dv_d = 1'b1;
                if (cnt_q == CW'(NPRE - 1)) begin
                    state_d = ST_SFD;
                    cnt_d   = '0;
                end
            end
            ST_SFD: begin
                rxd_d   = SFD_BYTE;
                rx_dv_d = 1'b1;
                crc_d   = CRC_INIT;
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                rd_addr = cnt_q[AW-1:0] + AW'(1);
                rx_dv_d = 1'b1;
                rxd_d   = rd_dat_q;
                crc_d   = crc_nxt;
                if (err_en_q && err_idx_q < len_q && cnt_q == CW'(err_idx_q)) begin
                    rxd_d   = rd_dat_q ^ 8'hFF;
                    rx_er_d = 1'b1;
                end
                if (cnt_q == CW'(len_q) - CW'(1)) begin
                    cnt_d = '0;
                    if (fcs_en_q) begin
                        state_d = ST_FCS;
                    end else begin
                        state_d  = ST_GAP;
                        frames_d = frames_q + CNTW'(1);
                    end
                end
            end
            ST_FCS: begin
                rx_dv_d = 1'b1;
                rxd_d   = fcs_val[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q[1:0] == 2'd3) begin
                    state_d  = ST_GAP;
                    cnt_d    = '0;
                    frames_d = frames_q + CNTW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(IFG - 1)) begin
                    cnt_d = '0;
                    if (rep_q == 16'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        rep_d   = rep_q - 16'd1;
                        state_d = ST_PRE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            fcs_en_q  <= 1'b0;
            err_en_q  <= 1'b0;
            err_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rxd_q     <= '0;
            rx_dv_q   <= 1'b0;
            rx_er_q   <= 1'b0;
            frames_q  <= '0;
            crc_q     <= CRC_INIT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rep_q     <= rep_d;
            fcs_en_q  <= fcs_en_d;
            err_en_q  <= err_en_d;
            err_idx_q <= err_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rxd_q     <= rxd_d;
            rx_dv_q   <= rx_dv_d;
            rx_er_q   <= rx_er_d;
            frames_q  <= frames_d;
            crc_q     <= crc_d;
        end
    end

    assign rxd         = rxd_q;
    assign rx_dv       = rx_dv_q;
    assign rx_er       = rx_er_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_q;

endmodule

// File: doc/gmii_frame_gen.md
Name: gmii_frame_gen

Overview:
Parametrised GMII receive-side frame generator. Replays frames from an internal byte buffer onto GMII rx signals, adding preamble, SFD, optional FCS, inter-frame gap, repeat count and single-byte error injection. It succeeds the shift-register frame stimulus used in the UDP-stack benches. It is synthesisable, so it also serves as an on-chip loopback source ahead of gmii2udp.

Parameters:
MAXNBYTES, 2048, frame buffer depth in bytes (power of two)
AW, $clog2(MAXNBYTES), buffer address width
IFG, 12, inter-frame gap in clocks, minimum 1
NPRE, 7, number of 0x55 preamble bytes, minimum 1
CNTW, 32, width of frames_sent counter

Ports:
clk  in  1  GMII clock, 125 MHz
resetn  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer byte address
wr_data  in  8  buffer byte
frame_len  in  AW+1  payload bytes to send, excluding FCS, 0..MAXNBYTES
start  in  1  single-cycle start pulse
repeat_cnt  in  16  number of frames per start
fcs_en  in  1  append computed CRC-32 FCS
err_en  in  1  enable error injection
err_idx  in  AW+1  payload index of the byte to corrupt
rxd  out  8  GMII data
rx_dv  out  1  GMII data valid
rx_er  out  1  GMII error
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last IFG
frames_sent  out  CNTW  total frames emitted since reset, wraps

Behaviour:
- Reset (async assert, sync deassert internally): rxd=0, rx_dv=0, rx_er=0, busy=0, done=0, frames_sent=0, state=IDLE. Buffer contents are undefined after reset.
- All outputs are registered.
- Buffer: single-port write, registered read (1-cycle latency). The read address is prefetched so payload bytes stream with no bubbles.
- Writes while busy are dropped.
- start is accepted only in IDLE with frame_len!=0 and repeat_cnt!=0. Otherwise it is ignored: no busy, no done.
- On acceptance, frame_len, repeat_cnt, fcs_en, err_en and err_idx are latched. Later input changes have no effect until done.
- FSM states: IDLE, PRE, SFD, DATA, FCS, GAP.
  - Accepted start at edge N: busy=1 at N+1. The first 0x55 appears on rxd with rx_dv=1 at N+2 (1 cycle to load the prefetch).
  - PRE: NPRE cycles of 0x55.
  - SFD: 1 cycle of 0xD5.
  - DATA: frame_len cycles; byte i = buf[i].
  - FCS: 4 cycles if fcs_en, else skipped.
  - GAP: IFG cycles with rx_dv=0 and rxd=0.
- After GAP: if frames remain, go to PRE; else go to IDLE, pulse done and drop busy in the same cycle.
- frames_sent increments on the last DATA/FCS byte of each frame and wraps at 2^CNTW.
- CRC-32, IEEE 802.3:
  - Reflected polynomial 0x04C11DB7, init 0xFFFFFFFF, computed over DATA bytes only.
  - Transmitted as the complement, LSB byte first.
  - CRC is reinitialised at every SFD.
- Error injection, when err_en and err_idx<frame_len, applies on DATA byte err_idx of every frame:
  - rx_er=1 and rxd = buf XOR 0xFF for that cycle.
  - CRC is computed over the uncorrupted byte, so the receiver must see an FCS mismatch.
  - err_idx>=frame_len: no injection.
- No padding is applied: frames shorter than 60 bytes are emitted as-is, so runt handling can be tested.
- frame_len>MAXNBYTES is clamped to MAXNBYTES.
- Reset mid-frame: rx_dv drops asynchronously, no done pulse, frames_sent cleared.

Decomposition:
- Package gmii_pkg: state enum, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY=32'h04C11DB7, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3.
- Sub-module crc32_d8: combinational next-CRC for an 8-bit data step. It is shared later with a GMII checker.

Test Plan:
- Write the ASCII "123456789" (0x31..0x39), frame_len=9, fcs_en=1, repeat=1, start → 7×0x55, 0xD5, 9 data bytes, then 0x26 0x39 0xF4 0xCB. rx_dv high for 21 cycles, first 0x55 two cycles after start, done exactly 21+12 cycles after the first preamble byte, frames_sent=1.
- Same frame, repeat_cnt=3, IFG=12 → three identical frames with exactly 12 idle cycles between them, frames_sent=3, one done pulse.
- err_en=1, err_idx=4 → byte 4 is 0xCA with rx_er=1 for that single cycle, FCS still 0x26 0x39 0xF4 0xCB. The gmii2udp CRC check reports an error.
- start while busy, start with frame_len=0, start with repeat_cnt=0, and wr_en while busy → all ignored; buffer contents and the frame in flight are unchanged.
- frame_len=MAXNBYTES, fcs_en=0, buffer filled with the address LSBs → a gapless 0x00..0xFF ramp on rxd, no FCS bytes, address wrap correct.
- Assert resetn=0 during DATA byte 5 → rx_dv=0 with no clock edge, busy=0, frames_sent=0. A restart afterwards produces a clean frame.
